// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the serial adder: FSM state encoding and default geometry.
// Optional feature macro used across the slice: SERIAL_ADDER_SUB_EN (adds the sub port).
package serial_adder_pkg;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_BITS_PER_CYCLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bus of the serial adder, with producer (master) and adder (slave) views.
// Macro SERIAL_ADDER_SUB_EN adds the sub select signal.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEF_WIDTH
);

  // Both channels are valid/ready: a transfer happens on a rising edge where valid and
  // ready are both 1; the source holds its payload while valid=1 and ready=0.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, overflow);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, overflow);
`endif

endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit combinational full adder; the serial adder chains these per RUN cycle.
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_cin;
  assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: consumes BITS_PER_CYCLE operand bits per RUN cycle, LSB first.
// Macro SERIAL_ADDER_SUB_EN enables subtraction (a + ~b + 1) through the sub signal.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder_if.slave    bus,
  output state_e           o_state
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);

  if (WIDTH < 2 || WIDTH > 64 || BITS_PER_CYCLE < 1 ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_geometry
    $error("serial_adder: WIDTH must be 2..64 and a multiple of BITS_PER_CYCLE");
  end

  state_e                    r_state;
  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [WIDTH-1:0]          r_sum;
  logic                      r_carry;
  logic                      r_cout;
  logic                      r_ovf;
  logic [CW-1:0]             r_cnt;

  logic                      w_sub;
  logic [WIDTH-1:0]          w_b_eff;
  logic                      w_cin_eff;
  logic                      w_accept;
  logic                      w_last;
  logic [BITS_PER_CYCLE:0]   w_c;
  logic [BITS_PER_CYCLE-1:0] w_s;
  logic [WIDTH-1:0]          w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is folded in at capture time so the datapath only ever adds.
  assign w_b_eff   = bus.b ^ {WIDTH{w_sub}};
  assign w_cin_eff = w_sub ? 1'b1 : bus.cin;
  assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
  assign w_last    = (r_cnt == CW'(N - 1));

  assign w_c[0] = r_carry;
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_fa
    fa_bit u_fa (
      .i_a     (r_a[gi]),
      .i_b     (r_b[gi]),
      .i_cin   (w_c[gi]),
      .o_sum   (w_s[gi]),
      .o_carry (w_c[gi+1])
    );
  end

  // New result bits enter at the top; after N cycles the first chunk sits at bit 0.
  if (BITS_PER_CYCLE == WIDTH) begin : g_sum_full
    assign w_sum_next = w_s;
  end else begin : g_sum_shift
    assign w_sum_next = {w_s, r_sum[WIDTH-1:BITS_PER_CYCLE]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> BITS_PER_CYCLE;
          r_b     <= r_b >> BITS_PER_CYCLE;
          r_sum   <= w_sum_next;
          r_carry <= w_c[BITS_PER_CYCLE];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= w_c[BITS_PER_CYCLE];
            r_ovf   <= w_c[BITS_PER_CYCLE] ^ w_c[BITS_PER_CYCLE-1];
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;
  assign o_state       = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one-bit-per-cycle and four-bits-per-cycle instances run side by side
// on the same operands; define SERIAL_ADDER_SUB_EN to also exercise subtraction.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic         d_in_valid;
  logic [W-1:0] d_a;
  logic [W-1:0] d_b;
  logic         d_cin;
  logic         d_sub;
  logic         d_out_ready;
  state_e       st1;
  state_e       st4;

  serial_adder_if #(.WIDTH(W)) if1 ();
  serial_adder_if #(.WIDTH(W)) if4 ();

  assign if1.in_valid  = d_in_valid;
  assign if1.a         = d_a;
  assign if1.b         = d_b;
  assign if1.cin       = d_cin;
  assign if1.out_ready = d_out_ready;
  assign if4.in_valid  = d_in_valid;
  assign if4.a         = d_a;
  assign if4.b         = d_b;
  assign if4.cin       = d_cin;
  assign if4.out_ready = d_out_ready;
`ifdef SERIAL_ADDER_SUB_EN
  assign if1.sub = d_sub;
  assign if4.sub = d_sub;
`endif

  serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .o_state(st1)
  );
  serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4), .o_state(st4)
  );

  // ---------------- scoreboard ----------------
  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [W+1:0] exp_q[$];  // {overflow, cout, sum}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic for the unsigned result, signed range for overflow.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
    int          bb;
    int          ci;
    int          total;
    int          s_total;
    logic [W-1:0] s;
    logic        co;
    logic        ov;
    bb      = sub ? ((~int'(b)) & ((1 << W) - 1)) : int'(b);
    ci      = sub ? 1 : int'(cin);
    total   = int'(a) + bb + ci;
    s       = total[W-1:0];
    co      = total[W];
    s_total = (int'(a) >= (1 << (W-1)) ? int'(a) - (1 << W) : int'(a)) +
              (bb >= (1 << (W-1)) ? bb - (1 << W) : bb) + ci;
    ov      = (s_total > (1 << (W-1)) - 1) || (s_total < -(1 << (W-1)));
    return {ov, co, s};
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int bp);
    int           k;
    int           lat1;
    int           lat4;
    logic         eff_sub;
    logic [W+1:0] exp;
`ifdef SERIAL_ADDER_SUB_EN
    eff_sub = sub;
`else
    eff_sub = 1'b0;
`endif
    exp_q.push_back(ref_add(a, b, cin, eff_sub));
    check_eq("in_ready1_idle", if1.in_ready, 1);
    check_eq("in_ready4_idle", if4.in_ready, 1);
    d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    d_a = W'($urandom); d_b = W'($urandom); d_cin = 1'($urandom); d_sub = 1'($urandom);
    k = 0; lat1 = 0; lat4 = 0;
    while ((lat1 == 0 || lat4 == 0) && k < 30) begin
      d_in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
      if (lat1 == 0 && if1.out_valid) lat1 = k;
      if (lat4 == 0 && if4.out_valid) lat4 = k;
    end
    d_in_valid = 1'b0;
    check_eq("latency1", lat1, 8);
    check_eq("latency4", lat4, 2);
    exp = exp_q.pop_front();
    check_eq("sum1", if1.sum, exp[W-1:0]);
    check_eq("cout1", if1.cout, exp[W]);
    check_eq("ovf1", if1.overflow, exp[W+1]);
    check_eq("sum4", if4.sum, exp[W-1:0]);
    check_eq("cout4", if4.cout, exp[W]);
    check_eq("ovf4", if4.overflow, exp[W+1]);
    for (int i = 0; i < bp; i++) begin
      d_in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("hold_valid1", if1.out_valid, 1);
      check_eq("hold_valid4", if4.out_valid, 1);
      check_eq("hold_inrdy1", if1.in_ready, 0);
      check_eq("hold_sum1", {if1.overflow, if1.cout, if1.sum}, exp);
      check_eq("hold_sum4", {if4.overflow, if4.cout, if4.sum}, exp);
    end
    // Operands offered during the completing handshake must not be taken.
    d_in_valid = 1'b1; d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_out_ready = 1'b0;
    check_eq("post_state1", st1, ST_IDLE);
    check_eq("post_state4", st4, ST_IDLE);
    check_eq("post_valid1", if1.out_valid, 0);
    check_eq("post_inrdy1", if1.in_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_state1"}, st1, ST_IDLE);
    check_eq({tag, "_state4"}, st4, ST_IDLE);
    check_eq({tag, "_inrdy1"}, if1.in_ready, 1);
    check_eq({tag, "_valid1"}, if1.out_valid, 0);
    check_eq({tag, "_valid4"}, if4.out_valid, 0);
    check_eq({tag, "_outs1"}, {if1.overflow, if1.cout, if1.sum}, 0);
    check_eq({tag, "_outs4"}, {if4.overflow, if4.cout, if4.sum}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
    d_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
    do_op(8'h3C, 8'hC3, 1'b1, 1'b0, 5);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 0);

    // Abort mid-operation: reset lands on the third RUN edge of the slow instance.
    d_a = 8'h55; d_b = 8'h11; d_cin = 1'b1; d_sub = 1'b0; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrun_rst");
    do_op(8'h05, 8'h03, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 2);
`endif

    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits, legal range 2..64.
REQ-002 Parameter BITS_PER_CYCLE, default 1, bits processed per RUN cycle; WIDTH % BITS_PER_CYCLE SHALL be 0 (elaboration error otherwise).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  subtract select; port exists only when SERIAL_ADDER_SUB_EN is defined.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB.
REQ-015 overflow  output  1  two's-complement overflow.

Function
REQ-016 FSM states IDLE, RUN, DONE; transitions IDLE->RUN on in_valid&&in_ready; RUN->DONE after N=WIDTH/BITS_PER_CYCLE RUN cycles; DONE->IDLE on out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 On accept, a, b, cin (and sub) SHALL be captured into internal shift registers; the bit counter and carry register SHALL be loaded with 0 and cin.
REQ-019 Each RUN cycle SHALL add the BITS_PER_CYCLE least-significant unprocessed bits, LSB first, through chained full-adder cells, shift the result into sum, and update the carry register.
REQ-020 Latency: accept on edge t, out_valid SHALL assert after edge t+N; for N=1 that is the edge following the accept.
REQ-021 sum, cout, overflow SHALL be held stable while out_valid=1 and out_ready=0 (backpressure, unbounded).
REQ-022 overflow SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-023 Operand inputs SHALL be ignored outside accept cycles; out_ready SHALL be ignored outside DONE.
REQ-024 DONE->IDLE handshake SHALL NOT accept new operands in the same cycle; in_ready rises the following cycle (one bubble per operation).
REQ-025 sum, cout, overflow are don't-care outside DONE; the implementation SHALL drive them from internal registers without X propagation.

Reset
REQ-026 rst=1 at any edge, including mid-RUN or in DONE, SHALL force IDLE, abort the operation, and clear counter, carry, shift registers, sum, cout, overflow to 0.
REQ-027 After reset: in_ready=1, out_valid=0.

Configuration
REQ-028 Macro SERIAL_ADDER_SUB_EN: when defined, sub port exists; sub=1 SHALL compute a + ~b + 1 (cin ignored), so cout=1 means no borrow.
REQ-029 Without SERIAL_ADDER_SUB_EN: no sub port, addition only (a + b + cin).

Structure
REQ-030 Package serial_adder_pkg SHALL hold the FSM state enum typedef and default WIDTH/BITS_PER_CYCLE constants.
REQ-031 Sub-module fa_bit (combinational one-bit full adder: a, b, cin -> sum, carry) SHALL be instantiated BITS_PER_CYCLE times in a generate chain.

Verification
REQ-032 WIDTH=8, BPC=1: a=FF, b=01, cin=0 -> sum=00, cout=1, overflow=0, out_valid exactly 8 cycles after accept.
REQ-033 WIDTH=8, BPC=1: a=7F, b=01, cin=0 -> sum=80, cout=0, overflow=1; a=80, b=80 -> sum=00, cout=1, overflow=1.
REQ-034 WIDTH=8, BPC=4: a=3C, b=C3, cin=1 -> sum=00, cout=1, overflow=0, latency 2 cycles.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 rst pulsed at RUN cycle 3 -> next cycle IDLE, out_valid=0, all outputs 0; subsequent a=05, b=03 -> sum=08.
REQ-037 SERIAL_ADDER_SUB_EN defined, WIDTH=8: a=05, b=07, sub=1 -> sum=FE, cout=0, overflow=0; a=80, b=01, sub=1 -> sum=7F, overflow=1.
